// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: initiator-side sequencer for a 64 x 16-bit register file.
// It accepts READ1/READ2/WRITE requests, drives reg_sel/mode/data_in, accounts for
// the file's one-cycle registered read latency, and returns operands on a
// valid/ready response channel.

`ifndef regModeIn
`define regModeIn 2'b01
`endif
`ifndef regModeOut
`define regModeOut 2'b10
`endif

module regfile_access_ctrl #(
  parameter int         WIDTH     = 16,
  parameter int         SEL_W     = 6,
  parameter logic [1:0] MODE_IN   = `regModeIn,
  parameter logic [1:0] MODE_OUT  = `regModeOut,
  parameter logic [1:0] MODE_IDLE = 2'b00
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [SEL_W-1:0] req_sel_a,
  input  logic [SEL_W-1:0] req_sel_b,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [SEL_W-1:0] rf_sel,
  output logic [1:0]       rf_mode,
  output logic [WIDTH-1:0] rf_data_in,
  input  logic [WIDTH-1:0] rf_data_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_B  = 3'd2,
    CAP_A = 3'd3,
    CAP_B = 3'd4,
    WR    = 3'd5,
    RESP  = 3'd6
  } state_t;

  localparam logic [1:0] OP_READ2 = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  state_t             state_q, state_d;
  logic               read2_q, read2_d;      // latched: request needs a second operand
  logic [SEL_W-1:0]   sel_b_q, sel_b_d;      // latched second source select
  logic [SEL_W-1:0]   rf_sel_q, rf_sel_d;
  logic [1:0]         rf_mode_q, rf_mode_d;
  logic [WIDTH-1:0]   rf_data_in_q, rf_data_in_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic               rsp_valid_q, rsp_valid_d;

  // Ready only while idle; RESP deliberately blocks a same-edge new accept.
  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign rf_sel     = rf_sel_q;
  assign rf_mode    = rf_mode_q;
  assign rf_data_in = rf_data_in_q;

  // Next-state and registered-output computation; rf_mode defaults to idle every cycle.
  always_comb begin
    state_d      = state_q;
    read2_d      = read2_q;
    sel_b_d      = sel_b_q;
    rf_sel_d     = rf_sel_q;
    rf_mode_d    = MODE_IDLE;
    rf_data_in_d = rf_data_in_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    rsp_valid_d  = rsp_valid_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rf_sel_d = req_sel_a;
          sel_b_d  = req_sel_b;
          if (req_op == OP_WRITE) begin
            state_d      = WR;
            rf_mode_d    = MODE_IN;
            rf_data_in_d = req_wdata;
            read2_d      = 1'b0;
          end else begin
            // Reserved op code falls through as a single-operand read.
            state_d   = RD_A;
            rf_mode_d = MODE_OUT;
            read2_d   = (req_op == OP_READ2);
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_A: begin
        if (read2_q) begin
          state_d   = RD_B;
          rf_sel_d  = sel_b_q;
          rf_mode_d = MODE_OUT;
        end else begin
          state_d = CAP_A;
        end
      end
      RD_B: begin
        // File output now holds R[sel_a]; R[sel_b] arrives on the next edge.
        op_a_d  = rf_data_out;
        state_d = CAP_B;
      end
      CAP_A: begin
        op_a_d      = rf_data_out;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      CAP_B: begin
        op_b_d      = rf_data_out;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      WR: begin
        // The file commits the write on this edge; nothing to return.
        state_d = IDLE;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q      <= IDLE;
      read2_q      <= 1'b0;
      sel_b_q      <= {SEL_W{1'b0}};
      rf_sel_q     <= {SEL_W{1'b0}};
      rf_mode_q    <= MODE_IDLE;
      rf_data_in_q <= {WIDTH{1'b0}};
      op_a_q       <= {WIDTH{1'b0}};
      op_b_q       <= {WIDTH{1'b0}};
      rsp_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      read2_q      <= read2_d;
      sel_b_q      <= sel_b_d;
      rf_sel_q     <= rf_sel_d;
      rf_mode_q    <= rf_mode_d;
      rf_data_in_q <= rf_data_in_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench for regfile_access_ctrl: a behavioural 64 x 16 register file
// sits on the rf_* port, and a transaction-level model predicts operands, latency
// and the number of write cycles.

module tb_regfile_access_ctrl;

  localparam logic [1:0] M_IN   = 2'b01;
  localparam logic [1:0] M_OUT  = 2'b10;
  localparam logic [1:0] M_IDLE = 2'b00;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [5:0]  req_sel_a = 6'd0;
  logic [5:0]  req_sel_b = 6'd0;
  logic [15:0] req_wdata = 16'h0000;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] op_a, op_b;
  logic [5:0]  rf_sel;
  logic [1:0]  rf_mode;
  logic [15:0] rf_data_in;
  logic [15:0] rf_data_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Register file environment and write-cycle monitor.
  bit [15:0] mem [64];
  int        in_cnt = 0;

  // Reference model state.
  bit [15:0] exp_mem [64];
  bit [15:0] exp_b_hold = 16'h0000;

  regfile_access_ctrl #(
    .WIDTH(16), .SEL_W(6), .MODE_IN(M_IN), .MODE_OUT(M_OUT), .MODE_IDLE(M_IDLE)
  ) dut (
    .clk(clk), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_sel_a(req_sel_a), .req_sel_b(req_sel_b), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .op_a(op_a), .op_b(op_b),
    .rf_sel(rf_sel), .rf_mode(rf_mode), .rf_data_in(rf_data_in), .rf_data_out(rf_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural register file: write on MODE_IN, registered read on MODE_OUT.
  always @(posedge clk) begin
    if (rf_mode == M_IN) mem[rf_sel] <= rf_data_in;
    else if (rf_mode == M_OUT) rf_data_out <= mem[rf_sel];
  end

  // Count cycles in which the file is told to write.
  always @(posedge clk) begin
    if (rf_mode == M_IN) in_cnt <= in_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction: drive, wait bounded, check against the model.
  task automatic do_req(input logic [1:0] op, input logic [5:0] a, input logic [5:0] b,
                        input logic [15:0] wd, input int hold);
    int          lat;
    int          in_before;
    logic [15:0] ea, eb;
    int          elat;
    @(negedge clk);
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_sel_a = a; req_sel_b = b; req_wdata = wd;
    in_before = in_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (op == 2'b10) begin
      exp_mem[a] = wd;
      chk("wr_ready_low", {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
      chk("wr_ready_back", {31'd0, req_ready}, 32'd1);
      chk("wr_file_data", {16'd0, mem[a]}, {16'd0, wd});
      chk("wr_in_cycles", in_cnt - in_before, 32'd1);
    end else begin
      ea   = exp_mem[a];
      eb   = (op == 2'b01) ? exp_mem[b] : exp_b_hold;
      elat = (op == 2'b01) ? 3 : 2;
      lat  = 0;
      for (int k = 1; k <= 12; k++) begin
        @(posedge clk);
        #1;
        if (rsp_valid) begin
          lat = k;
          break;
        end
      end
      chk("rd_latency", lat, elat);
      chk("rd_op_a", {16'd0, op_a}, {16'd0, ea});
      chk("rd_op_b", {16'd0, op_b}, {16'd0, eb});
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        #1;
        chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
        chk("hold_op_a", {16'd0, op_a}, {16'd0, ea});
        chk("hold_op_b", {16'd0, op_b}, {16'd0, eb});
        chk("hold_ready_low", {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk("rsp_done_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rsp_done_ready", {31'd0, req_ready}, 32'd1);
      chk("rd_no_write", in_cnt - in_before, 32'd0);
      exp_b_hold = eb;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rf_mode"}, {30'd0, rf_mode}, {30'd0, M_IDLE});
    chk({tag, "_rf_sel"}, {26'd0, rf_sel}, 32'd0);
    chk({tag, "_rf_data_in"}, {16'd0, rf_data_in}, 32'd0);
    chk({tag, "_op_a"}, {16'd0, op_a}, 32'd0);
    chk({tag, "_op_b"}, {16'd0, op_b}, 32'd0);
  endtask

  initial begin
    int in_before;
    logic [1:0] rop;
    // Power-on reset.
    #2;
    chk_reset_outputs("reset");
    repeat (3) @(negedge clk);
    clear = 1'b1;
    #1;
    chk("reset_ready", {31'd0, req_ready}, 32'd1);

    // Preload through the controller, then a two-operand read.
    do_req(2'b10, 6'd1, 6'd0, 16'h0001, 0);
    do_req(2'b10, 6'd2, 6'd0, 16'h8000, 0);
    do_req(2'b10, 6'd3, 6'd0, 16'hFFFF, 0);
    do_req(2'b01, 6'd1, 6'd2, 16'h0000, 0);

    // Top register write then single read.
    do_req(2'b10, 6'd63, 6'd0, 16'hBEEF, 0);
    do_req(2'b00, 6'd63, 6'd0, 16'h0000, 0);

    // Consumer back-pressure for five cycles.
    do_req(2'b01, 6'd2, 6'd1, 16'h0000, 5);

    // Same register on both operands.
    do_req(2'b01, 6'd3, 6'd3, 16'h0000, 1);

    // Reset asserted while the second read is in flight.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_sel_a = 6'd1; req_sel_b = 6'd3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    clear = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("midreset_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    @(negedge clk);
    clear = 1'b1;
    exp_b_hold = 16'h0000;
    do_req(2'b00, 6'd2, 6'd0, 16'h0000, 0);

    // Back-to-back writes to one register, then read it.
    in_before = in_cnt;
    do_req(2'b10, 6'd5, 6'd0, 16'h0001, 0);
    do_req(2'b10, 6'd5, 6'd0, 16'h0002, 0);
    chk("b2b_in_cycles", in_cnt - in_before, 32'd2);
    do_req(2'b00, 6'd5, 6'd0, 16'h0000, 0);

    // Randomized traffic against the model, biased toward boundary selects.
    for (int t = 0; t < 80; t++) begin
      logic [5:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom_range(0, 63));
      rb  = ($urandom_range(0, 3) == 0) ? 6'd0  : 6'($urandom_range(0, 63));
      do_req(rop, ra, rb, 16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Initiator-side sequencer that drives the 64 x 16-bit register file port: `reg_sel`, `mode`, `data_in`, and captures `data_out`.
- Accepts operand-read and writeback requests from the datapath over a valid/ready interface.
- Issues register-file accesses, accounting for the file's one-cycle registered read latency.
- Returns captured operands over a valid/ready response channel. It sits between the decode/execute logic and the register file.

Parameters:
- WIDTH, 16, data word width (matches `WORD`).
- SEL_W, 6, register select width (64 registers).
- MODE_IN, `regModeIn, mode code for a register-file write.
- MODE_OUT, `regModeOut, mode code for a register-file read.
- MODE_IDLE, 2'b00, mode code for no access. Must differ from MODE_IN and MODE_OUT; override if it collides.

Ports:
- clk  in  1  system clock, all state on rising edge.
- clear  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  2  00 READ1, 01 READ2, 10 WRITE, 11 reserved (treated as READ1).
- req_sel_a  in  SEL_W  first source / write destination register.
- req_sel_b  in  SEL_W  second source register (READ2 only).
- req_wdata  in  WIDTH  write data (WRITE only).
- rsp_valid  out  1  operands valid.
- rsp_ready  in  1  consumer accepts response.
- op_a  out  WIDTH  value of R[sel_a].
- op_b  out  WIDTH  value of R[sel_b] (READ2); holds previous value otherwise.
- rf_sel  out  SEL_W  to register file `reg_sel`.
- rf_mode  out  2  to register file `mode`.
- rf_data_in  out  WIDTH  to register file `data_in`.
- rf_data_out  in  WIDTH  from register file `data_out` (registered in file, valid one cycle after MODE_OUT edge).

Behaviour:
- Reset (clear low, asynchronous):
  - state=IDLE, rsp_valid=0, rf_mode=MODE_IDLE, rf_sel=0, rf_data_in=0, op_a=0, op_b=0.
  - req_ready=1 once clear deasserts.
  - Reset mid-operation aborts the access: no response is produced and no further write is issued.
- All rf_* outputs and op_a/op_b/rsp_valid are registered; req_ready=(state==IDLE) is combinational.
- Handshake:
  - A request is accepted on an edge with req_valid & req_ready; req_* fields are latched at that edge.
  - A response completes on an edge with rsp_valid & rsp_ready.
  - rsp_valid and op_a/op_b hold stable until accepted.
- FSM states: IDLE, RD_A, RD_B, CAP_A, CAP_B, WR, RESP.
  - IDLE → READ*: go to RD_A; rf_sel=sel_a, rf_mode=MODE_OUT.
  - IDLE → WRITE: go to WR; rf_sel=sel_a, rf_mode=MODE_IN, rf_data_in=wdata.
  - RD_A, READ2: go to RD_B; rf_sel=sel_b, rf_mode=MODE_OUT.
  - RD_A, READ1: go to CAP_A; rf_mode=MODE_IDLE.
  - RD_B: capture op_a<=rf_data_out; go to CAP_B; rf_mode=MODE_IDLE.
  - CAP_A: capture op_a<=rf_data_out; rsp_valid<=1; go to RESP.
  - CAP_B: capture op_b<=rf_data_out; rsp_valid<=1; go to RESP.
  - WR: the register file writes at the end of this cycle; rf_mode<=MODE_IDLE; go to IDLE. WRITE produces no response.
  - RESP: on rsp_ready, rsp_valid<=0 and go to IDLE. The same edge does not accept a new request, since req_ready=0 in RESP.
- Latency, measured from the accept edge E0:
  - READ1: rsp_valid high after E2.
  - READ2: rsp_valid high after E3.
  - WRITE: register updated at E1; req_ready high again after E1.
- Ordering:
  - A READ accepted after a WRITE to the same register returns the new value; no bypass is needed because the write completes before the read issues.
  - READ2 with sel_a==sel_b returns the same value on both operands.
- rf_mode is MODE_IDLE in every cycle not listed above, so no spurious writes occur. rf_sel and rf_data_in hold their last values while idle.
- Full 6-bit select range: registers 0 and 63 are both legal; no wrap-around logic.

Test Plan:
- Reset, then READ2 sel_a=1, sel_b=2 against a file holding R1=1, R2=16'h8000 → rsp_valid after 3 cycles with op_a=16'h0001, op_b=16'h8000; rf_mode never equals MODE_IN.
- WRITE sel_a=63, wdata=16'hBEEF, then READ1 sel_a=63 → file R63=16'hBEEF one edge after accept; read returns op_a=16'hBEEF after 2 cycles.
- READ2 with rsp_ready held low for 5 cycles → rsp_valid, op_a, op_b stable, req_ready=0 throughout; completes on the first rsp_ready edge, req_ready=1 the next cycle.
- READ2 sel_a=sel_b=3 (R3=16'hFFFF) → op_a=op_b=16'hFFFF.
- Assert clear low during RD_B of a READ2 → all outputs return to reset values immediately; no rsp_valid; after release, a READ1 sel_a=2 returns 16'h8000.
- Back-to-back WRITE R5=16'h0001, WRITE R5=16'h0002, READ1 R5 → op_a=16'h0002; exactly two MODE_IN cycles observed on rf_mode.
